// File: rtl/neuron_mac.sv
// Sequential single-neuron MAC: streams N_INPUTS (activation, weight) pairs, adds a bias, then scales and clamps the result.
// Optional feature macro NEURON_MUL_PIPE_EN registers the product ahead of the accumulator.
module neuron_mac #(
    parameter int N_INPUTS = 784,
    parameter int IN_W     = 8,
    parameter int W_W      = 16,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 32,
    parameter int SHIFT    = 8,
    parameter int OUT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIAS_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [W_W-1:0]    in_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready may depend on state only, valid is never withdrawn by this block once raised.
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH, S_DONE} state_t;

    localparam int PROD_W = IN_W + W_W + 1;
    localparam int MAX_AP = (ACC_W > PROD_W) ? ACC_W : PROD_W;
    localparam int WIDE_W = ((MAX_AP > BIAS_W) ? MAX_AP : BIAS_W) + 1;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);

    localparam logic signed [WIDE_W-1:0] ACC_MAX_WIDE =
        {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] ACC_MIN_WIDE =
        {{(WIDE_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    state_t state_q, state_d;

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [BIAS_W-1:0] bias_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [OUT_W-1:0]         out_q, out_d;

    logic                     beat;
    logic                     last_beat;
    logic signed [PROD_W-1:0] data_ext, weight_ext, prod;
    logic                     add_en;
    logic signed [PROD_W-1:0] add_val;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  scaled;

    // Clamp a wide signed sum into the accumulator range instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [WIDE_W-1:0] x);
        if (x > ACC_MAX_WIDE)
            return {1'b0, {(ACC_W-1){1'b1}}};
        else if (x < ACC_MIN_WIDE)
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return x[ACC_W-1:0];
    endfunction

    assign data_ext   = PROD_W'($signed({1'b0, in_data}));
    assign weight_ext = PROD_W'($signed(in_weight));
    assign prod       = data_ext * weight_ext;

    assign beat      = in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_W'(N_INPUTS - 1));

`ifdef NEURON_MUL_PIPE_EN
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_vld_q;
    logic                     drain_q;

    assign in_ready = (state_q == S_ACCUM) && !drain_q;
    assign add_en   = prod_vld_q;
    assign add_val  = prod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            prod_vld_q <= beat;
            if (beat)
                prod_q <= prod;
            if (state_q == S_IDLE && start)
                drain_q <= 1'b0;
            else if (beat && last_beat)
                drain_q <= 1'b1;
            else if (state_q == S_ACCUM && drain_q)
                drain_q <= 1'b0;
        end
    end
`else
    assign in_ready = (state_q == S_ACCUM);
    assign add_en   = beat;
    assign add_val  = prod;
`endif

    assign acc_next = sat_acc(WIDE_W'(acc_q) + WIDE_W'(add_val));
    assign biased   = sat_acc(WIDE_W'(acc_q) + WIDE_W'(bias_q));
    assign scaled   = biased >>> SHIFT;

    always_comb begin
        out_d = '0;
        if (scaled[ACC_W-1])
            out_d = '0;
        else if ((scaled >>> OUT_W) != '0)
            out_d = '1;
        else
            out_d = scaled[OUT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACCUM;
`ifdef NEURON_MUL_PIPE_EN
            S_ACCUM:  if (drain_q) state_d = S_FINISH;
`else
            S_ACCUM:  if (beat && last_beat) state_d = S_FINISH;
`endif
            S_FINISH: state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            bias_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                bias_q <= $signed(bias);
                acc_q  <= '0;
                cnt_q  <= '0;
            end else begin
                if (add_en)
                    acc_q <= acc_next;
                if (beat)
                    cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_FINISH)
                out_q <= out_d;
        end
    end

    assign out_valid   = (state_q == S_DONE);
    assign out_data    = out_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule
